// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - LSB-first parallel-in/serial-out transmitter; `PISO_PARITY_EN appends an even-parity bit
module piso_serializer #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] par_in,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         serial_out,
   output logic         serial_valid,
   output logic         last
);

   localparam int CW = $clog2(N+1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t         state, nxt_state;
   logic [N-1:0]   sreg, nxt_sreg;
   logic [CW-1:0]  cnt, nxt_cnt;
   logic           nxt_ready, nxt_out, nxt_valid, nxt_last;
   logic           hs, at_end, do_load;
`ifdef PISO_PARITY_EN
   logic           par, nxt_par;
`endif

   assign hs     = load_valid && load_ready;
   assign at_end = (cnt == CW'(N-1));

   // Next-state: accept a word, shift one bit per cycle, close the frame
   always_comb begin
      nxt_state = state;
      nxt_sreg  = sreg;
      nxt_cnt   = cnt;
      do_load   = 1'b0;
`ifdef PISO_PARITY_EN
      nxt_par   = par;
`endif
      case (state)
         IDLE: begin
            do_load = hs;
         end
         SHIFT: begin
            nxt_sreg = {1'b0, sreg[N-1:1]};
            nxt_cnt  = cnt + CW'(1);
            if (at_end) begin
               nxt_cnt = '0;
`ifdef PISO_PARITY_EN
               nxt_state = PARITY;
`else
               nxt_state = IDLE;
               do_load   = hs;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            nxt_state = IDLE;
            do_load   = hs;
         end
`endif
         default: begin
            nxt_state = IDLE;
            nxt_sreg  = '0;
            nxt_cnt   = '0;
         end
      endcase
      if (do_load) begin
         nxt_state = SHIFT;
         nxt_sreg  = par_in;
         nxt_cnt   = '0;
`ifdef PISO_PARITY_EN
         nxt_par   = ^par_in;
`endif
      end
   end

   // Output decode from the upcoming state so the outputs can be registered
   always_comb begin
      nxt_ready = 1'b1;
      nxt_valid = 1'b0;
      nxt_out   = 1'b0;
      nxt_last  = 1'b0;
      case (nxt_state)
         SHIFT: begin
            nxt_valid = 1'b1;
            nxt_out   = nxt_sreg[0];
`ifdef PISO_PARITY_EN
            nxt_ready = 1'b0;
`else
            nxt_ready = (nxt_cnt == CW'(N-1));
            nxt_last  = (nxt_cnt == CW'(N-1));
`endif
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            nxt_valid = 1'b1;
            nxt_out   = nxt_par;
            nxt_last  = 1'b1;
            nxt_ready = 1'b1;
         end
`endif
         default: begin
            nxt_ready = 1'b1;
         end
      endcase
   end

   // State and registered outputs; reset aborts any frame in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sreg         <= '0;
         cnt          <= '0;
         load_ready   <= 1'b1;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         last         <= 1'b0;
`ifdef PISO_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         state        <= nxt_state;
         sreg         <= nxt_sreg;
         cnt          <= nxt_cnt;
         load_ready   <= nxt_ready;
         serial_out   <= nxt_out;
         serial_valid <= nxt_valid;
         last         <= nxt_last;
`ifdef PISO_PARITY_EN
         par          <= nxt_par;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized bench for piso_serializer against a bit-queue reference model
module tb_piso_serializer;

   localparam int N = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = N + 1;
`else
   localparam int FL = N;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] par_in = '0;
   logic         load_valid = 1'b0;
   logic         load_ready, serial_out, serial_valid, last;

   int tests = 0;
   int fails = 0;

   bit           q[$];
   logic [N-1:0] words[$];
   logic [N-1:0] ds = '0;
   int           fpos = 0;

   always #5 clk = ~clk;

   piso_serializer #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .par_in       (par_in),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .last         (last)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q.delete();
      words.delete();
      fpos = 0;
   endtask

   task automatic check_outputs();
      bit eo;
      eo = (q.size() > 0) ? q[0] : 1'b0;
      check("load_ready",   load_ready,   q.size() <= 1);
      check("serial_valid", serial_valid, q.size() > 0);
      check("serial_out",   serial_out,   eo);
      check("last",         last,         q.size() == 1);
   endtask

   task automatic step(input logic v, input logic [N-1:0] d);
      bit acc;
      @(negedge clk);
      check_outputs();
      if (serial_valid) begin
         if (fpos < N) ds = {serial_out, ds[N-1:1]};
         if (fpos == N-1) begin
            if (words.size() > 0) check("deser_word", ds, words.pop_front());
            else check("deser_pending", words.size(), 1);
         end
         fpos = (fpos + 1) % FL;
      end
      load_valid = v;
      par_in     = d;
      @(posedge clk);
      acc = v && (q.size() <= 1) && !rst;
      if (rst) begin
         model_clear();
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (acc) begin
            for (int i = 0; i < N; i++) q.push_back(d[i]);
`ifdef PISO_PARITY_EN
            q.push_back(^d);
`endif
            words.push_back(d);
         end
      end
   endtask

   task automatic pulse_reset(input logic [N-1:0] d);
      #2 rst = 1'b1;
      model_clear();
      #1 check_outputs();
      step(1'b1, d);
      #2 rst = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      #2 check_outputs();
      @(negedge clk);
      rst = 1'b0;

      step(1'b1, 8'hA5);
      repeat (FL + 2) step(1'b0, N'($urandom));

      step(1'b1, 8'hA5);
      repeat (FL) step(1'b1, 8'h3C);
      repeat (FL + 2) step(1'b0, '0);

      step(1'b1, 8'hA5);
      repeat (FL) step(1'b1, 8'hFF);
      repeat (FL + 2) step(1'b0, '0);

      step(1'b1, 8'h07);
      repeat (FL + 2) step(1'b0, '0);

      step(1'b1, 8'hA5);
      repeat (3) step(1'b0, '0);
      pulse_reset(8'h0F);
      step(1'b1, 8'h0F);
      repeat (FL + 2) step(1'b0, '0);

      for (int c = 0; c < 800; c++) begin
         step($urandom_range(0, 3) != 0, N'($urandom));
         if ($urandom_range(0, 79) == 0) pulse_reset(N'($urandom));
      end

      repeat (FL + 3) step(1'b0, '0);
      check("words_drained", words.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter: accepts an N-bit word on a valid/ready handshake and shifts it out one bit per clock, LSB first. A right-shifting, MSB-input deserializer of the same width sampling `serial_out` on `serial_valid` cycles holds the original word after N valid bits. The block sits at the transmit end of a serial link.

## Interface
- `N`, default 8: data word width; legal range N ≥ 2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `par_in`  in  N  parallel word; sampled only on a load handshake.
- `load_valid`  in  1  the source presents a word on `par_in`.
- `load_ready`  out  1  the block can accept a word this cycle.
- `serial_out`  out  1  current serial bit.
- `serial_valid`  out  1  `serial_out` carries a frame bit this cycle.
- `last`  out  1  the current bit is the final bit of the frame.

## Operation
- Internal state:
  - `sreg[N-1:0]` holds the shift data.
  - `cnt` is a $clog2(N+1)-bit bit index.
  - The FSM has three states: IDLE, SHIFT and PARITY. PARITY exists only with the macro.
- Load handshake: a word is accepted on a rising edge where `load_valid && load_ready`. On that edge:
  - `sreg <= par_in`, `cnt <= 0`, state becomes SHIFT.
  - With the macro, the parity bit `par <= ^par_in` is also captured.
- IDLE:
  - `load_ready`=1, `serial_valid`=0, `serial_out`=0, `last`=0.
- SHIFT:
  - `serial_valid`=1 and `serial_out`=`sreg[0]`.
  - Each edge: `sreg <= {1'b0, sreg[N-1:1]}` and `cnt <= cnt+1`.
  - When `cnt`==N-1 without the macro:
    - `last`=1 and `load_ready`=1.
    - Next state is SHIFT with the new word if a handshake occurs on that edge; otherwise IDLE.
  - When `cnt`==N-1 with the macro: next state is PARITY, and `load_ready`=0.
- PARITY (macro only):
  - `serial_valid`=1, `serial_out`=`par`, `last`=1, `load_ready`=1.
  - Next state is SHIFT if a handshake occurs on that edge; otherwise IDLE.
- `load_ready` is low on all other SHIFT cycles. `load_valid` held high during those cycles is neither accepted nor lost; the source simply waits.
- No combinational path from any input to any output. Every output is a function of registered state only.
- `par_in` is don't-care when no handshake occurs.

## Timing
- Reset values (asserted and immediately after release):
  - State IDLE, `sreg`=0, `cnt`=0.
  - `load_ready`=1, `serial_out`=0, `serial_valid`=0, `last`=0.
- Asserting `rst` mid-frame aborts the frame asynchronously. The partially sent word is discarded and not resumed.
- A handshake is ignored while `rst` is high.
- Latency: for a word accepted at edge k, bit i is on `serial_out` during the cycle following edge k+i, for i = 0..N-1.
- Frame length: N cycles without the macro, N+1 cycles with it.
- Back-to-back frames: a handshake on the final-bit edge starts the next frame with no idle cycle.
- Sustained throughput: one word per N cycles, or per N+1 cycles with the macro.

## Configuration
- Macro `PISO_PARITY_EN`.
- When defined:
  - An even-parity bit (XOR of the N data bits) is appended as one extra `serial_valid` cycle after bit N-1.
  - `last` moves to the parity cycle, and `load_ready` asserts only on the parity cycle.
- When undefined:
  - There is no PARITY state and no `par` register.
  - Frames are exactly N bits, and `last`/`load_ready` assert on bit N-1.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle.
  - Outputs immediately read `load_ready`=1, `serial_valid`=0, `serial_out`=0 and `last`=0.
- Single frame (N=8, macro off): load 0xA5 at edge 0.
  - Cycles 1..8 show `serial_out` = 1,0,1,0,0,1,0,1 with `serial_valid`=1.
  - `last`=1 only in cycle 8, then the block returns to IDLE.
- Back-to-back (N=8): 0xA5, then 0x3C presented with `load_valid` held high throughout.
  - 0x3C is accepted on the edge ending cycle 8.
  - Cycles 9..16 show 0,0,1,1,1,1,0,0 with no gap in `serial_valid`.
- Stall: hold `load_valid`=1 with 0xFF during cycles 1..7 of a frame.
  - `load_ready`=0 on those cycles and 0xFF is not accepted until the final-bit edge.
- Reset mid-frame: assert `rst` during cycle 4 of 0xA5.
  - `serial_valid` drops immediately.
  - A fresh load of 0x0F after release transmits 1,1,1,1,0,0,0,0.
- Parity (`PISO_PARITY_EN`, N=8):
  - 0xA5 gives parity bit 0 in cycle 9 with `last`=1.
  - 0x07 gives parity bit 1.
  - Loopback into an N-bit right-shift MSB-input deserializer yields q==0xA5 after the 8 data bits.
